core_controller: RTL

Sequencing controller for the single-cycle RV32I datapath. Decodes `Op`/`F3`/`F7` with the `Zero`/`SignBit` flags into the datapath control word: immediate type, ALU operation, write enables and every mux select. Adds the sequential behaviour the datapath lacks:

- PC-enable gating.
- A request/acknowledge handshake to a wait-stated data memory.
- A memory timeout.
- A sticky fault state.
- A retired-instruction counter.

It sits beside the datapath; the datapath's PC register and data memory are extended with `pc_en` and `mem_req`/`mem_ack`.

---
 rtl/core_ctrl_pkg.sv | 70 +++++++
 rtl/instr_decoder.sv | 93 +++++++++
 rtl/core_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the RV32I sequencing controller: opcodes, control-word
// fields, mux selects and FSM states.
package core_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_IMM  = 2'd1;
  localparam logic [1:0] NPC_JALR = 2'd2;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_SLT = 2'd2;

  typedef enum logic [1:0] {BOOT, EXEC, MEM_WAIT, FAULT} state_t;

  typedef struct packed {
    logic [2:0] imm_op;
    logic [2:0] alu_op;
    logic [1:0] m4_1_cnt;
    logic [1:0] m4_2_cnt;
    logic       m2_1_cnt;
    logic       m2_2_cnt;
    logic       m2_3_cnt;
    logic       m2_4_cnt;
    logic       reg_we;
    logic       mem_we;
  } ctrl_t;

  // slt/slti compare by subtraction; the sign of the difference is the result.
  function automatic logic [2:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b010:  return ALU_SUB;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic alu_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
           (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I subset decoder: control word plus memory/illegal flags.
// Zero latency; no handshaking.
module instr_decoder
  import core_ctrl_pkg::*;
(
  input  logic [6:0] Op,
  input  logic [2:0] F3,
  input  logic [6:0] F7,
  input  logic       Zero,
  input  logic       SignBit,
  output ctrl_t      ctrl,
  output logic       is_mem,
  output logic       is_load,
  output logic       illegal
);

  logic taken;

  always_comb begin
    ctrl    = '0;
    is_mem  = 1'b0;
    is_load = 1'b0;
    illegal = 1'b0;
    taken   = 1'b0;
    case (Op)
      OP_R, OP_I: begin
        ctrl.reg_we   = 1'b1;
        ctrl.m2_1_cnt = (Op == OP_I);
        ctrl.alu_op   = alu_from_f3(F3);
        illegal       = !alu_f3_ok(F3);
        if (Op == OP_R) begin
          if (F7 == F7_ALT) begin
            ctrl.alu_op = ALU_SUB;
            illegal     = (F3 != 3'b000);
          end else if (F7 != F7_BASE) begin
            illegal = 1'b1;
          end
        end
        if (F3 == F3_SLT) begin
          ctrl.m4_2_cnt = RES_SLT;
          ctrl.m2_3_cnt = SignBit;
        end
      end
      OP_LOAD: begin
        ctrl.m2_1_cnt = 1'b1;
        ctrl.m4_2_cnt = RES_MEM;
        ctrl.reg_we   = 1'b1;
        is_mem        = 1'b1;
        is_load       = 1'b1;
        illegal       = (F3 != F3_WORD);
      end
      OP_STORE: begin
        ctrl.imm_op   = IMM_S;
        ctrl.m2_1_cnt = 1'b1;
        ctrl.mem_we   = 1'b1;
        is_mem        = 1'b1;
        illegal       = (F3 != F3_WORD);
      end
      OP_BRANCH: begin
        ctrl.imm_op = IMM_B;
        ctrl.alu_op = ALU_SUB;
        case (F3)
          3'b000:  taken = Zero;
          3'b001:  taken = !Zero;
          3'b100:  taken = SignBit;
          3'b101:  taken = !SignBit;
          default: illegal = 1'b1;
        endcase
        ctrl.m4_1_cnt = taken ? NPC_IMM : NPC_SEQ;
      end
      OP_JAL: begin
        ctrl.imm_op   = IMM_J;
        ctrl.m4_1_cnt = NPC_IMM;
        ctrl.m2_2_cnt = 1'b1;
        ctrl.reg_we   = 1'b1;
      end
      OP_JALR: begin
        ctrl.m2_1_cnt = 1'b1;
        ctrl.m4_1_cnt = NPC_JALR;
        ctrl.m2_2_cnt = 1'b1;
        ctrl.reg_we   = 1'b1;
        illegal       = (F3 != 3'b000);
      end
      OP_LUI: begin
        ctrl.imm_op   = IMM_U;
        ctrl.m2_4_cnt = 1'b1;
        ctrl.reg_we   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_controller.sv
// Sequencing controller: Mealy control word (0 cycles), memory instructions stall
// the PC until mem_ack or timeout; illegal opcodes and timeouts park in sticky FAULT.
module core_controller
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic [2:0]       F3,
  input  logic [6:0]       F7,
  input  logic             Zero,
  input  logic             SignBit,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             reg_we,
  output logic             mem_we,
  output logic             mem_req,
  output logic [2:0]       imm_op,
  output logic [2:0]       alu_op,
  output logic [1:0]       m4_1_cnt,
  output logic [1:0]       m4_2_cnt,
  output logic             m2_1_cnt,
  output logic             m2_2_cnt,
  output logic             m2_3_cnt,
  output logic             m2_4_cnt,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  ctrl_t      dec, ctrl;
  logic       is_mem, is_load, illegal;
  logic [7:0] wait_cnt;

  instr_decoder u_dec (
    .Op      (Op),
    .F3      (F3),
    .F7      (F7),
    .Zero    (Zero),
    .SignBit (SignBit),
    .ctrl    (dec),
    .is_mem  (is_mem),
    .is_load (is_load),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:     state_nxt = EXEC;
      EXEC: begin
        if (illegal)     state_nxt = FAULT;
        else if (is_mem) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_ack)                    state_nxt = EXEC;
        else if (wait_cnt == WAIT_LAST) state_nxt = FAULT;
      end
      default:  state_nxt = FAULT;
    endcase
  end

  // The instruction is held stable through MEM_WAIT because the PC is frozen,
  // so the live decode is still valid there.
  always_comb begin
    ctrl    = '0;
    pc_en   = 1'b0;
    mem_req = 1'b0;
    fault   = 1'b0;
    case (state)
      EXEC: begin
        if (!illegal) begin
          ctrl = dec;
          if (is_mem) begin
            mem_req     = 1'b1;
            ctrl.reg_we = 1'b0;
            ctrl.mem_we = 1'b0;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        ctrl        = dec;
        mem_req     = 1'b1;
        pc_en       = mem_ack;
        ctrl.reg_we = mem_ack && is_load;
        ctrl.mem_we = mem_ack && !is_load;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  wait_cnt <= '0;
    else if (state != MEM_WAIT) wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       instret <= '0;
    else if (pc_en) instret <= instret + CNT_W'(1);
  end

  assign reg_we   = ctrl.reg_we;
  assign mem_we   = ctrl.mem_we;
  assign imm_op   = ctrl.imm_op;
  assign alu_op   = ctrl.alu_op;
  assign m4_1_cnt = ctrl.m4_1_cnt;
  assign m4_2_cnt = ctrl.m4_2_cnt;
  assign m2_1_cnt = ctrl.m2_1_cnt;
  assign m2_2_cnt = ctrl.m2_2_cnt;
  assign m2_3_cnt = ctrl.m2_3_cnt;
  assign m2_4_cnt = ctrl.m2_4_cnt;

endmodule
